// File: rtl/rl_fifo_1r1w_ctrl.sv
// Streaming FIFO controller around a 1R1W RAM with a 2-entry first-word-fall-through output queue.
// Optional flush port enabled by defining RL_FIFO_CTRL_FLUSH_EN.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS  = 4,
  parameter int DBITS  = 32,
  parameter int AF_LVL = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef RL_FIFO_CTRL_FLUSH_EN
  input  logic                   flush_i,
`endif
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [DBITS-1:0]       push_data_i,
  output logic                   pop_valid_o,
  input  logic                   pop_ready_i,
  output logic [DBITS-1:0]       pop_data_o,
  output logic [ABITS+1:0]       count_o,
  output logic                   almost_full_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int RDEPTH = 1 << ABITS;
  localparam int DEPTH  = RDEPTH + 2;
  localparam int CW     = ABITS + 2;
  localparam int RCW    = ABITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);

  logic             clr;
  logic [ABITS-1:0] wptr, rptr;
  logic [RCW-1:0]   ram_cnt;
  logic             rd_pend;
  logic [DBITS-1:0] oq [2];
  logic [DBITS-1:0] oq_nxt [2];
  logic [1:0]       oq_cnt, oq_cnt_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             af;
  logic             push_fire, pop_fire, bypass;
  logic [2:0]       pipe_after_pop, oq_after_pop;

`ifdef RL_FIFO_CTRL_FLUSH_EN
  assign clr = rst_i | flush_i;
`else
  assign clr = rst_i;
`endif

  assign push_ready_o = !clr && (cnt < DEPTH_C);
  assign pop_valid_o  = !clr && (oq_cnt != 2'd0);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = pop_valid_o & pop_ready_i;

  // Bypass only when nothing older sits in RAM or the read pipe, so order holds.
  assign oq_after_pop   = {1'b0, oq_cnt} - {2'b0, pop_fire};
  assign pipe_after_pop = {1'b0, oq_cnt} + {2'b0, rd_pend} - {2'b0, pop_fire};
  assign bypass = push_fire && (ram_cnt == '0) && !rd_pend && (oq_after_pop < 3'd2);

  assign ram_we_o    = push_fire && !bypass;
  assign ram_waddr_o = wptr;
  assign ram_din_o   = push_data_i;
  assign ram_be_o    = '1;
  assign ram_re_o    = !clr && (ram_cnt != '0) && (pipe_after_pop < 3'd2);
  assign ram_raddr_o = rptr;

  assign pop_data_o    = oq[0];
  assign count_o       = cnt;
  assign almost_full_o = af;

  // Pop shifts first; returning RAM data or bypassed data then lands at the tail.
  always_comb begin
    oq_nxt[0]  = oq[0];
    oq_nxt[1]  = oq[1];
    oq_cnt_nxt = oq_cnt;
    if (pop_fire) begin
      oq_nxt[0]  = oq[1];
      oq_cnt_nxt = oq_cnt - 2'd1;
    end
    if (rd_pend) begin
      oq_nxt[oq_cnt_nxt[0]] = ram_dout_i;
      oq_cnt_nxt            = oq_cnt_nxt + 2'd1;
    end else if (bypass) begin
      oq_nxt[oq_cnt_nxt[0]] = push_data_i;
      oq_cnt_nxt            = oq_cnt_nxt + 2'd1;
    end
  end

  assign cnt_nxt = cnt + CW'(push_fire) - CW'(pop_fire);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
      oq[0]   <= '0;
      oq[1]   <= '0;
      oq_cnt  <= '0;
      cnt     <= '0;
      af      <= 1'b0;
    end else begin
      if (ram_we_o) wptr <= wptr + 1'b1;
      if (ram_re_o) rptr <= rptr + 1'b1;
      ram_cnt <= ram_cnt + RCW'(ram_we_o) - RCW'(ram_re_o);
      rd_pend <= ram_re_o;
      oq[0]   <= oq_nxt[0];
      oq[1]   <= oq_nxt[1];
      oq_cnt  <= oq_cnt_nxt;
      cnt     <= cnt_nxt;
      af      <= (DEPTH_C - cnt_nxt) <= AF_C;
    end
  end

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl: vector table plus queue-model sequences for fill, stream, wrap, reset.
module tb_rl_fifo_1r1w_ctrl;
  localparam int ABITS = 4, DBITS = 32, AF = 4, DEPTH = 18;

  logic clk = 1'b0, rst = 1'b1, pv = 1'b0, pr = 1'b0;
  logic [DBITS-1:0] pd = '0;
  logic push_ready, pop_valid, af, ram_we, ram_re;
  logic [DBITS-1:0] pop_data, ram_din, ram_dout;
  logic [ABITS+1:0] count;
  logic [ABITS-1:0] ram_waddr, ram_raddr;
  logic [3:0] ram_be;
  logic [DBITS-1:0] mem [16];

  int tests = 0, fails = 0;
  logic [DBITS-1:0] q[$];

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .AF_LVL(AF)) dut (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(pv), .push_ready_o(push_ready), .push_data_i(pd),
    .pop_valid_o(pop_valid), .pop_ready_i(pr), .pop_data_o(pop_data),
    .count_o(count), .almost_full_o(af),
    .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_raddr_o(ram_raddr), .ram_re_o(ram_re), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  typedef struct {
    logic pv; logic [31:0] d; logic pr;
    logic e_prdy; logic e_pval; logic [31:0] e_data; logic [5:0] e_cnt; logic e_we; logic e_re;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk); #1;
    pv = v; pd = d; pr = r;
    @(negedge clk);
  endtask

  // One cycle against the queue model: checks registered status, then scores fires.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    drive(v, d, r);
    chk("count", 32'(count), q.size());
    chk("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
    chk("almost_full", 32'(af), 32'((DEPTH - q.size()) <= AF));
    if (pop_valid && pr) begin
      if (q.size() == 0) chk("pop_underflow", 32'(pop_valid), 32'd0);
      else chk("pop_data", pop_data, q.pop_front());
    end
    if (pv && push_ready) q.push_back(d);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
    chk(nm, q.size(), 0);
    cycle(1'b0, '0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'hA5A50001, 1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'hA5A50002, 1'b0, 1'b1, 1'b1, 32'hA5A50001, 6'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'hA5A50003, 1'b0, 1'b1, 1'b1, 32'hA5A50001, 6'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50001, 6'd3, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A50002, 6'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50002, 6'd2, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A50003, 6'd1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        6'd0, 1'b0, 1'b0};

    // reset held with push requested
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD0000, 1'b0);
      chk("rst_push_ready", 32'(push_ready), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_re", 32'(ram_re), 0);
      chk("rst_pop_valid", 32'(pop_valid), 0);
    end
    @(posedge clk); #1; rst = 1'b0; pv = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_pop_valid", 32'(pop_valid), 0);
    chk("post_rst_af", 32'(af), 0);
    chk("post_rst_push_ready", 32'(push_ready), 1);
    chk("ram_be", 32'(ram_be), 32'hF);

    // bypass / RAM path vectors
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].pv, tbl[i].d, tbl[i].pr);
      chk($sformatf("vec%0d_push_ready", i), 32'(push_ready), 32'(tbl[i].e_prdy));
      chk($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].e_pval));
      if (tbl[i].e_pval) chk($sformatf("vec%0d_pop_data", i), pop_data, tbl[i].e_data);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d_re", i), 32'(ram_re), 32'(tbl[i].e_re));
    end

    // fill to full, then drain in order
    for (int i = 1; i <= 20; i++) cycle(1'b1, 32'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("fill_count", 32'(count), 18);
    chk("fill_push_ready", 32'(push_ready), 0);
    chk("fill_af", 32'(af), 1);
    drain("fill_drain");

    // streaming after prefill of 2
    cycle(1'b1, 32'd0, 1'b0);
    cycle(1'b1, 32'd1, 1'b0);
    for (int k = 2; k < 1000; k++) begin
      cycle(1'b1, 32'(k), 1'b1);
      if (pop_valid !== 1'b1) chk("stream_pop_valid", 32'(pop_valid), 1);
    end
    tests++;
    drain("stream_drain");

    // pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) cycle(1'b1, 32'(r * 100 + i), 1'b0);
      drain("wrap_drain");
    end

    // reset with a RAM read in flight
    cycle(1'b1, 32'hB0, 1'b0);
    cycle(1'b1, 32'hB1, 1'b0);
    cycle(1'b1, 32'hB2, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("inflight_re", 32'(ram_re), 1);
    @(posedge clk); #1; rst = 1'b1; pv = 1'b1; pr = 1'b1;
    @(negedge clk);
    chk("mid_rst_pop_valid", 32'(pop_valid), 0);
    chk("mid_rst_push_ready", 32'(push_ready), 0);
    chk("mid_rst_re", 32'(ram_re), 0);
    @(posedge clk); #1; rst = 1'b0; pv = 1'b0; pr = 1'b0;
    q.delete();
    @(negedge clk);
    chk("after_rst_count", 32'(count), 0);
    chk("after_rst_pop_valid", 32'(pop_valid), 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h77, 1'b1);
    drain("after_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
